// File: rtl/uart_rx_deserializer.sv
// UART 8N1 receive deserializer: synchronises the RX line, qualifies start bits,
// samples each bit near its centre, checks the stop bit and hands the byte to the
// consumer through a dataReady/readAck handshake with sticky overrun reporting.
module uart_rx_deserializer #(
    parameter int unsigned clocksPerBit = 87,
    parameter int unsigned halfBit      = (clocksPerBit - 1) / 2
) (
    input  logic       clkRx,
    input  logic       rst,
    input  logic       serialIn,
    output logic [7:0] dataOut,
    output logic       dataReady,
    input  logic       readAck,
    output logic       frameError,
    output logic       overrun,
    output logic       busy
);

    localparam int unsigned CntW = $clog2(clocksPerBit);
    localparam logic [CntW-1:0] HalfCnt = CntW'(halfBit);
    localparam logic [CntW-1:0] LastCnt = CntW'(clocksPerBit - 1);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StStop,
        StBreak
    } rxState_t;

    logic            syncMeta;
    logic            rxSync;
    rxState_t        stateQ, stateD;
    logic [CntW-1:0] clkCountQ, clkCountD;
    logic [2:0]      bitIndexQ, bitIndexD;
    logic [7:0]      shiftQ, shiftD;
    logic [7:0]      dataOutQ, dataOutD;
    logic            dataReadyQ, dataReadyD;
    logic            frameErrorQ, frameErrorD;
    logic            overrunQ, overrunD;
    logic            goodByte;

    // Two-flop synchroniser; resets to the idle-high line level.
    always_ff @(posedge clkRx or posedge rst) begin
        if (rst) begin
            syncMeta <= 1'b1;
            rxSync   <= 1'b1;
        end else begin
            syncMeta <= serialIn;
            rxSync   <= syncMeta;
        end
    end

    // State, counters, shift register and output registers.
    always_ff @(posedge clkRx or posedge rst) begin
        if (rst) begin
            stateQ      <= StIdle;
            clkCountQ   <= '0;
            bitIndexQ   <= '0;
            shiftQ      <= '0;
            dataOutQ    <= '0;
            dataReadyQ  <= 1'b0;
            frameErrorQ <= 1'b0;
            overrunQ    <= 1'b0;
        end else begin
            stateQ      <= stateD;
            clkCountQ   <= clkCountD;
            bitIndexQ   <= bitIndexD;
            shiftQ      <= shiftD;
            dataOutQ    <= dataOutD;
            dataReadyQ  <= dataReadyD;
            frameErrorQ <= frameErrorD;
            overrunQ    <= overrunD;
        end
    end

    // Next-state logic for the receive FSM and the consumer handshake.
    always_comb begin
        stateD      = stateQ;
        clkCountD   = clkCountQ;
        bitIndexD   = bitIndexQ;
        shiftD      = shiftQ;
        dataOutD    = dataOutQ;
        dataReadyD  = dataReadyQ;
        frameErrorD = 1'b0;
        overrunD    = overrunQ;
        goodByte    = 1'b0;

        unique case (stateQ)
            StIdle: begin
                clkCountD = '0;
                bitIndexD = '0;
                if (!rxSync) stateD = StStart;
            end
            StStart: begin
                if (clkCountQ == HalfCnt) begin
                    clkCountD = '0;
                    // A line back high at mid-start is a glitch, not a frame.
                    stateD    = rxSync ? StIdle : StData;
                end else begin
                    clkCountD = clkCountQ + 1'b1;
                end
            end
            StData: begin
                if (clkCountQ == LastCnt) begin
                    shiftD[bitIndexQ] = rxSync;
                    clkCountD         = '0;
                    if (bitIndexQ == 3'd7) begin
                        bitIndexD = '0;
                        stateD    = StStop;
                    end else begin
                        bitIndexD = bitIndexQ + 3'd1;
                    end
                end else begin
                    clkCountD = clkCountQ + 1'b1;
                end
            end
            StStop: begin
                if (clkCountQ == LastCnt) begin
                    clkCountD = '0;
                    if (rxSync) begin
                        goodByte = 1'b1;
                        stateD   = StIdle;
                    end else begin
                        frameErrorD = 1'b1;
                        stateD      = StBreak;
                    end
                end else begin
                    clkCountD = clkCountQ + 1'b1;
                end
            end
            StBreak: begin
                // Wait for the line to return high so a held-low line is not a new start.
                clkCountD = '0;
                if (rxSync) stateD = StIdle;
            end
            default: stateD = StIdle;
        endcase

        if (goodByte) begin
            if (!dataReadyQ || readAck) begin
                dataOutD   = shiftD;
                dataReadyD = 1'b1;
            end else begin
                overrunD = 1'b1;
            end
        end else if (readAck) begin
            dataReadyD = 1'b0;
            overrunD   = 1'b0;
        end
    end

    assign dataOut    = dataOutQ;
    assign dataReady  = dataReadyQ;
    assign frameError = frameErrorQ;
    assign overrun    = overrunQ;
    assign busy       = (stateQ != StIdle);

endmodule

// File: tb/tb_uart_rx_deserializer.sv
// Self-checking bench for uart_rx_deserializer: table of frames plus hand-written
// sequences for the glitch and break corner cases.
module tb_uart_rx_deserializer;

    localparam int Cpb  = 87;
    localparam int Half = 43;
    localparam int StopEdge = 3 + Half + 9 * Cpb;  // 829

    logic       clkRx = 1'b0;
    logic       rst;
    logic       serialIn;
    logic [7:0] dataOut;
    logic       dataReady;
    logic       readAck;
    logic       frameError;
    logic       overrun;
    logic       busy;

    int nChecks = 0;
    int nPass   = 0;

    uart_rx_deserializer #(
        .clocksPerBit(Cpb),
        .halfBit     (Half)
    ) dut (
        .clkRx     (clkRx),
        .rst       (rst),
        .serialIn  (serialIn),
        .dataOut   (dataOut),
        .dataReady (dataReady),
        .readAck   (readAck),
        .frameError(frameError),
        .overrun   (overrun),
        .busy      (busy)
    );

    always #5 clkRx = ~clkRx;

    typedef struct {
        logic [7:0] data;
        logic       stopBit;
        logic       ackBefore;
        logic       ackAtStop;
        int         rstAt;
        logic       holdLow;
        logic       expPre;
        logic [7:0] expData;
        logic       expReady;
        logic       expOverrun;
        logic       expFe;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act === exp) nPass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic pulseAck();
        @(negedge clkRx);
        readAck = 1'b1;
        @(negedge clkRx);
        readAck = 1'b0;
        check("ackClearsReady", {31'd0, dataReady}, 32'd1 - 32'd1);
        check("ackClearsOverrun", {31'd0, overrun}, 32'd0);
    endtask

    // Drives one 8N1 frame; cycle c=0 is the edge k that first samples the start bit.
    task automatic sendFrame(input vec_t v, input int idx);
        logic bitVal;
        int   b;
        for (int c = 0; c < 10 * Cpb; c++) begin
            @(negedge clkRx);
            b = c / Cpb;
            if (b == 0) bitVal = 1'b0;
            else if (b <= 8) bitVal = v.data[b-1];
            else bitVal = v.stopBit;
            serialIn = bitVal;
            readAck  = v.ackAtStop && (c == StopEdge);
            if (c == v.rstAt) rst = 1'b1;
            if (c == v.rstAt + 1) begin
                rst = 1'b0;
                #1;
                check($sformatf("v%0d rstData", idx), {24'd0, dataOut}, 32'd0);
                check($sformatf("v%0d rstFlags", idx),
                      {28'd0, dataReady, overrun, frameError, busy}, 32'd0);
            end
            @(posedge clkRx);
            #1;
            if (c == StopEdge - 1)
                check($sformatf("v%0d readyPre", idx), {31'd0, dataReady}, {31'd0, v.expPre});
            if (c == StopEdge) begin
                check($sformatf("v%0d dataOut", idx), {24'd0, dataOut}, {24'd0, v.expData});
                check($sformatf("v%0d ready", idx), {31'd0, dataReady}, {31'd0, v.expReady});
                check($sformatf("v%0d overrun", idx), {31'd0, overrun}, {31'd0, v.expOverrun});
                check($sformatf("v%0d frameErr", idx), {31'd0, frameError}, {31'd0, v.expFe});
            end
            if (c == StopEdge + 1)
                check($sformatf("v%0d frameErrEnd", idx), {31'd0, frameError}, 32'd0);
        end
        readAck = 1'b0;
    endtask

    initial begin
        //          data   stop ackB ackS rstAt           hold pre  expD   rdy  ov   fe
        vecs[0] = '{8'hA5, 1'b1, 1'b0, 1'b0, -10,          1'b0, 1'b0, 8'hA5, 1'b1, 1'b0, 1'b0};
        vecs[1] = '{8'h3C, 1'b1, 1'b1, 1'b0, -10,          1'b0, 1'b0, 8'h3C, 1'b1, 1'b0, 1'b0};
        vecs[2] = '{8'hC3, 1'b1, 1'b0, 1'b0, -10,          1'b0, 1'b1, 8'h3C, 1'b1, 1'b1, 1'b0};
        vecs[3] = '{8'hC3, 1'b1, 1'b1, 1'b0, -10,          1'b0, 1'b0, 8'hC3, 1'b1, 1'b0, 1'b0};
        vecs[4] = '{8'h96, 1'b1, 1'b0, 1'b1, -10,          1'b0, 1'b1, 8'h96, 1'b1, 1'b0, 1'b0};
        vecs[5] = '{8'h55, 1'b0, 1'b0, 1'b0, -10,          1'b1, 1'b1, 8'h96, 1'b1, 1'b0, 1'b1};
        vecs[6] = '{8'h12, 1'b1, 1'b1, 1'b0, -10,          1'b0, 1'b0, 8'h12, 1'b1, 1'b0, 1'b0};
        vecs[7] = '{8'hFF, 1'b1, 1'b0, 1'b0, 5 * Cpb + 40, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0};
        vecs[8] = '{8'h81, 1'b1, 1'b0, 1'b0, -10,          1'b0, 1'b0, 8'h81, 1'b1, 1'b0, 1'b0};

        rst      = 1'b1;
        serialIn = 1'b1;
        readAck  = 1'b0;
        repeat (3) @(posedge clkRx);
        @(negedge clkRx);
        rst = 1'b0;
        repeat (5) @(negedge clkRx);
        check("resetData", {24'd0, dataOut}, 32'd0);
        check("resetFlags", {28'd0, dataReady, overrun, frameError, busy}, 32'd0);

        for (int i = 0; i < 9; i++) begin
            if (vecs[i].ackBefore) pulseAck();
            sendFrame(vecs[i], i);
            if (vecs[i].holdLow) begin
                // Line still low after the bad stop bit: must stay in BREAK.
                repeat (300) @(negedge clkRx);
                check("breakBusy", {31'd0, busy}, 32'd1);
                check("breakReady", {31'd0, dataReady}, 32'd1);
                check("breakFrameErr", {31'd0, frameError}, 32'd0);
                serialIn = 1'b1;
                repeat (4) @(negedge clkRx);
                check("breakExit", {31'd0, busy}, 32'd0);
            end
            repeat (3) @(negedge clkRx);
        end

        // Start glitch: low for 20 cycles only; START re-check at k+46 returns to IDLE.
        for (int c = 0; c <= 50; c++) begin
            @(negedge clkRx);
            serialIn = (c < 20) ? 1'b0 : 1'b1;
            @(posedge clkRx);
            #1;
            if (c == 45) check("glitchBusyHi", {31'd0, busy}, 32'd1);
            if (c == 46) check("glitchBusyLo", {31'd0, busy}, 32'd0);
            if (c == 30) check("glitchNoFe", {31'd0, frameError}, 32'd0);
        end
        check("glitchData", {24'd0, dataOut}, 32'h81);
        check("glitchReady", {30'd0, dataReady, overrun}, 32'd2);

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
